// File: rtl/alu_result_fifo.sv
// Purpose: first-word-fall-through FIFO buffering ALU mux results with tag and status flags.
// Latency: 1 cycle from a push into an empty FIFO to out_valid; there is no same-cycle bypass.
// Backpressure: in_ready = !full, driven from registered state only; out_* hold while out_ready=0.
module alu_result_fifo #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic                     out_par,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry layout: flags are captured at enqueue so the consumer never recomputes them.
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] dat;
    logic             zero;
    logic             neg;
    logic             par;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  entry_t          w_wr_entry;
  entry_t          w_head;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid & ~w_full;
  assign w_pop   = out_valid & out_ready;

  // Build the stored entry, including status flags derived from the incoming value.
  always_comb begin
    w_wr_entry      = '0;
    w_wr_entry.sel  = in_sel;
    w_wr_entry.dat  = in_data;
    w_wr_entry.zero = ~|in_data;
    w_wr_entry.neg  = in_data[WIDTH-1];
    w_wr_entry.par  = ^in_data;
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  // Pointer and occupancy update; reset wins over any simultaneous push or pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Occupancy must never pass DEPTH; the port handshake makes this unreachable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (r_count <= CW'(DEPTH));
    end
  end

  // Head presentation; all data and flag outputs are forced low while empty.
  always_comb begin
    w_head = r_mem[r_rd_ptr];
    if (w_empty) begin
      w_head = '0;
    end
  end

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign out_data  = w_head.dat;
  assign out_sel   = w_head.sel;
  assign out_zero  = w_head.zero;
  assign out_neg   = w_head.neg;
  assign out_par   = w_head.par;
  assign count     = r_count;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: reset, single pass, fill, drain with wrap,
// simultaneous push/pop and reset during traffic, checked with immediate assertions.
module tb_alu_result_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_sel;
  logic       out_zero;
  logic       out_neg;
  logic       out_par;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  alu_result_fifo #(.WIDTH(8), .SEL_W(3), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_par   (out_par),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] s);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    tick();
    in_valid = 1'b0;
  endtask

  logic [7:0] push_d [4];
  logic [2:0] push_s [4];
  logic [7:0] exp_d  [8];
  logic [2:0] exp_s  [8];

  initial begin
    int pidx;
    int oidx;
    push_d = '{8'h1E, 8'hA2, 8'h99, 8'h00};
    push_s = '{3'd5, 3'd6, 3'd7, 3'd0};
    exp_d  = '{8'h85, 8'h5B, 8'hF6, 8'h72, 8'h1E, 8'hA2, 8'h99, 8'h00};
    exp_s  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

    // 1. Reset held two cycles with in_valid asserted.
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h55; in_sel = 3'd7; out_ready = 1'b0;
    #1;
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_sel", 32'(out_sel), 0);
    chk("rst_flags", 32'({out_zero, out_neg, out_par}), 0);
    reset = 1'b0; in_valid = 1'b0;
    tick();
    chk("rst_nothing_enq", 32'(count), 0);

    // 2. Single pass.
    push(8'b0111_1011, 3'd0);
    chk("single_valid", 32'(out_valid), 1);
    chk("single_data", 32'(out_data), 32'h7B);
    chk("single_sel", 32'(out_sel), 0);
    chk("single_flags", 32'({out_zero, out_neg, out_par}), 0);
    chk("single_count", 32'(count), 1);
    tick();
    chk("single_hold", 32'(out_data), 32'h7B);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_pop_count", 32'(count), 0);
    chk("single_pop_valid", 32'(out_valid), 0);
    chk("single_pop_data", 32'(out_data), 0);

    // 3. Fill to full; a fifth push is refused.
    push(8'h85, 3'd1);
    chk("fill_head", 32'(out_data), 32'h85);
    chk("fill_head_flags", 32'({out_zero, out_neg, out_par}), 32'b011);
    push(8'h5B, 3'd2);
    push(8'hF6, 3'd3);
    push(8'h72, 3'd4);
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    push(8'h1E, 3'd5);
    chk("refused_count", 32'(count), 4);
    chk("refused_head", 32'(out_data), 32'h85);

    // 4. Drain with pushes into freed slots; pointers wrap.
    pidx = 0;
    oidx = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && oidx < 8; cyc++) begin
      in_valid = (pidx < 4);
      in_data  = (pidx < 4) ? push_d[pidx] : 8'h00;
      in_sel   = (pidx < 4) ? push_s[pidx] : 3'd0;
      if (out_valid) begin
        chk($sformatf("drain_data%0d", oidx), 32'(out_data), 32'(exp_d[oidx]));
        chk($sformatf("drain_sel%0d", oidx), 32'(out_sel), 32'(exp_s[oidx]));
        if (oidx == 7) chk("drain_zero_flags", 32'({out_zero, out_neg, out_par}), 32'b100);
        oidx++;
      end
      if (in_valid && in_ready) pidx++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("drain_all_seen", 32'(oidx), 8);
    chk("drain_count", 32'(count), 0);
    chk("drain_valid", 32'(out_valid), 0);

    // 5. Simultaneous push and pop with count=2.
    push(8'hAA, 3'd1);
    push(8'h3C, 3'd2);
    chk("simul_pre_count", 32'(count), 2);
    in_valid = 1'b1; in_data = 8'h0F; in_sel = 3'd3; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("simul_count", 32'(count), 2);
    chk("simul_head", 32'(out_data), 32'h3C);
    chk("simul_head_sel", 32'(out_sel), 2);
    tick();
    chk("simul_tail", 32'(out_data), 32'h0F);
    chk("simul_tail_sel", 32'(out_sel), 3);
    chk("simul_tail_count", 32'(count), 1);
    tick();
    out_ready = 1'b0;
    chk("simul_empty", 32'(count), 0);

    // 6. Reset with traffic on both sides.
    push(8'h11, 3'd1);
    push(8'h22, 3'd2);
    push(8'h33, 3'd3);
    chk("midrst_pre_count", 32'(count), 3);
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h44; in_sel = 3'd4; out_ready = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_data", 32'(out_data), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("midrst_no_stale%0d", k), 32'(out_valid), 0);
    end
    out_ready = 1'b0;
    push(8'h66, 3'd6);
    chk("post_rst_head", 32'(out_data), 32'h66);
    chk("post_rst_sel", 32'(out_sel), 6);
    chk("post_rst_count", 32'(count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
